// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file definitions used by decode, the register
// file and the hazard scoreboard.
package legv8_pkg;

    // Register 31 reads as zero and discards writes.
    localparam logic [4:0] XZR   = 5'd31;
    localparam int         NREGS = 32;

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter for the hazard scoreboard.
// An increment and an effective decrement in the same cycle cancel. A
// decrement at zero has no effect and is reported on underflow instead.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             zero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             dec_eff;

    assign zero      = (count_reg == '0);
    assign sat       = (count_reg == CNT_MAX);
    assign underflow = dec && zero;
    assign dec_eff   = dec && !zero;
    assign count     = count_reg;

    // Net up/down step; simultaneous inc and effective dec leave the count alone.
    always_comb begin
        count_next = count_reg;
        if (inc && !dec_eff) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!inc && dec_eff) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: tracks outstanding writes per architectural
// register, stalls issue on unsafe source reads or counter overflow, and
// watches the register-file writeback port to retire writes.
module reg_scoreboard
    import legv8_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_ra1,
    input  logic [4:0]  issue_ra2,
    input  logic        issue_use1,
    input  logic        issue_use2,
    input  logic        issue_we,
    input  logic [4:0]  issue_wa,
    output logic        issue_ready,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    output logic [31:0] busy_mask,
    output logic [7:0]  inflight,
    output logic        err_underflow
);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] zero_vec;
    logic [NREGS-1:0] sat_vec;
    logic [NREGS-1:0] uf_vec;

    logic       src1_hazard;
    logic       src2_hazard;
    logic       dst_hazard;
    logic       inc_any;
    logic       dec_any;
    logic [7:0] inflight_reg;
    logic [7:0] inflight_next;
    logic       err_reg;
    logic       err_next;

    // One counter per register; XZR is never tracked and reads as idle.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_cnt
            if (gi == int'(XZR)) begin : g_tie
                assign cnt[gi]      = '0;
                assign zero_vec[gi] = 1'b1;
                assign sat_vec[gi]  = 1'b0;
                assign uf_vec[gi]   = 1'b0;
            end else begin : g_ctr
                sb_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk       (clk),
                    .reset     (reset),
                    .inc       (inc_any && (issue_wa == reg_addr_t'(gi))),
                    .dec       (wb_we && (wb_wa == reg_addr_t'(gi))),
                    .count     (cnt[gi]),
                    .sat       (sat_vec[gi]),
                    .zero      (zero_vec[gi]),
                    .underflow (uf_vec[gi])
                );
            end
        end
    endgenerate

    // Hazard comparators; a last outstanding write retiring this cycle is
    // forwarded by the register file, and a retiring write frees a slot.
    always_comb begin
        src1_hazard = issue_use1 && (issue_ra1 != XZR) && !zero_vec[issue_ra1]
                      && !((cnt[issue_ra1] == CNT_W'(1)) && wb_we && (wb_wa == issue_ra1));
        src2_hazard = issue_use2 && (issue_ra2 != XZR) && !zero_vec[issue_ra2]
                      && !((cnt[issue_ra2] == CNT_W'(1)) && wb_we && (wb_wa == issue_ra2));
        dst_hazard  = issue_we && (issue_wa != XZR) && sat_vec[issue_wa]
                      && !(wb_we && (wb_wa == issue_wa));
        issue_ready = !src1_hazard && !src2_hazard && !dst_hazard;
    end

    assign inc_any = issue_valid && issue_ready && issue_we && (issue_wa != XZR);
    assign dec_any = wb_we && (wb_wa != XZR) && !zero_vec[wb_wa];

    // Total in-flight count follows the same net-zero rule as the counters;
    // the error flag is sticky until reset.
    always_comb begin
        inflight_next = inflight_reg + {7'd0, inc_any} - {7'd0, dec_any};
        err_next      = err_reg | (|uf_vec);
    end

    // Accumulator and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            err_reg      <= err_next;
        end
    end

    assign busy_mask     = ~zero_vec;
    assign inflight      = inflight_reg;
    assign err_underflow = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a per-register count model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_reg_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_ra1;
    logic [4:0]  issue_ra2;
    logic        issue_use1;
    logic        issue_use2;
    logic        issue_we;
    logic [4:0]  issue_wa;
    logic        issue_ready;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] busy_mask;
    logic [7:0]  inflight;
    logic        err_underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    int m_cnt [32];
    bit m_err = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ra1     (issue_ra1),
        .issue_ra2     (issue_ra2),
        .issue_use1    (issue_use1),
        .issue_use2    (issue_use2),
        .issue_we      (issue_we),
        .issue_wa      (issue_wa),
        .issue_ready   (issue_ready),
        .wb_we         (wb_we),
        .wb_wa         (wb_wa),
        .busy_mask     (busy_mask),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit src_ok(input bit use_k, input int ra);
        if (!use_k || ra == 31 || m_cnt[ra] == 0) return 1;
        return (m_cnt[ra] == 1) && wb_we && (int'(wb_wa) == ra);
    endfunction

    function automatic bit m_ready();
        bit dst_ok;
        dst_ok = !issue_we || issue_wa == 5'd31 || m_cnt[issue_wa] < MAXC
                 || (wb_we && wb_wa == issue_wa);
        return src_ok(issue_use1, int'(issue_ra1)) && src_ok(issue_use2, int'(issue_ra2)) && dst_ok;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 0; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    // Model update at each rising edge from the inputs held across it.
    always @(posedge clk) begin
        bit acc;
        acc = issue_valid && m_ready();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            if (wb_we && wb_wa != 5'd31) begin
                if (m_cnt[wb_wa] == 0) m_err = 1;
                else m_cnt[wb_wa] = m_cnt[wb_wa] - 1;
            end
            if (acc && issue_we && issue_wa != 5'd31) m_cnt[issue_wa] = m_cnt[issue_wa] + 1;
        end
    end

    // Compare process: mid-cycle, after inputs settle.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("issue_ready", issue_ready, m_ready());
            check("busy_mask", busy_mask, m_busy());
            check("inflight", inflight, m_total());
            check("err_underflow", err_underflow, m_err);
        end
    end

    // Apply one cycle of stimulus at the falling edge, then wait for settle.
    task automatic cyc(input bit rst, input bit v, input int ra1, input bit u1,
                       input int ra2, input bit u2, input bit we, input int wa,
                       input bit wbe, input int wba);
        @(negedge clk);
        reset       = rst;
        issue_valid = v;
        issue_ra1   = 5'(ra1);
        issue_use1  = u1;
        issue_ra2   = 5'(ra2);
        issue_use2  = u2;
        issue_we    = we;
        issue_wa    = 5'(wa);
        wb_we       = wbe;
        wb_wa       = 5'(wba);
        #3;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick();
        return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1; issue_valid = 0; issue_ra1 = 0; issue_ra2 = 0; issue_use1 = 0;
        issue_use2 = 0; issue_we = 0; issue_wa = 0; wb_we = 0; wb_wa = 0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;

        // Idle after reset
        cyc(0, 0, 13, 1, 20, 1, 0, 0, 0, 0);
        check("lit_rst_ready", issue_ready, 1);
        check("lit_rst_busy", busy_mask, 0);
        check("lit_rst_inflight", inflight, 0);

        // X5 write, then forwarding release
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        cyc(0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        check("lit_x5_stall", issue_ready, 0);
        check("lit_x5_busy", busy_mask[5], 1);
        cyc(0, 1, 5, 1, 0, 0, 0, 0, 1, 5);
        check("lit_x5_fwd", issue_ready, 1);
        idle();
        check("lit_x5_clear", busy_mask[5], 0);
        check("lit_x5_inflight", inflight, 0);

        // X7 saturation
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        check("lit_x7_sat_stall", issue_ready, 0);
        check("lit_x7_inflight3", inflight, 3);
        cyc(0, 1, 0, 0, 0, 0, 1, 7, 1, 7);
        check("lit_x7_sat_wb", issue_ready, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        check("lit_x7_still3", inflight, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle();
        check("lit_x7_drained", inflight, 0);

        // XZR never tracked
        cyc(0, 1, 0, 0, 0, 0, 1, 31, 0, 0);
        cyc(0, 0, 31, 1, 31, 1, 0, 0, 1, 31);
        check("lit_xzr_busy", busy_mask, 0);
        check("lit_xzr_inflight", inflight, 0);
        check("lit_xzr_ready", issue_ready, 1);
        idle();
        check("lit_xzr_err", err_underflow, 0);

        // Underflow on X3, sticky through traffic
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        check("lit_uf_set", err_underflow, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 9, 1, 6);
        idle();
        check("lit_uf_sticky", err_underflow, 1);
        check("lit_pend_inflight", inflight, 2);

        // Reset beats an accepted issue to X4
        cyc(1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
        idle();
        check("lit_rst_inflight2", inflight, 0);
        check("lit_rst_busy2", busy_mask, 0);
        check("lit_rst_err", err_underflow, 0);

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                pick(), $urandom_range(0, 1), pick(), $urandom_range(0, 1),
                $urandom_range(0, 1), pick(),
                $urandom_range(0, 1), pick());
        end

        idle();
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
